// File: rtl/inst_sram_loader_if.sv
// CPU inst_sram port plus the boot-loader byte stream, bundled for the
// instruction-memory responder. master = CPU/debug side, slave = responder.
interface inst_sram_loader_if #(
   parameter int ADDR_WIDTH = 12
);
   logic                  inst_sram_en;
   logic [3:0]            inst_sram_we;
   logic [31:0]           inst_sram_addr;
   logic [31:0]           inst_sram_wdata;
   logic [31:0]           inst_sram_rdata;
   logic                  ld_start;
   logic [ADDR_WIDTH:0]   ld_len;
   logic                  ld_valid;
   logic [7:0]            ld_byte;
   logic                  ld_ready;
   logic                  ld_busy;
   logic                  ld_done;
   logic                  cpu_hold;

   modport master (
      output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
      output ld_start, ld_len, ld_valid, ld_byte,
      input  inst_sram_rdata, ld_ready, ld_busy, ld_done, cpu_hold
   );

   modport slave (
      input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
      input  ld_start, ld_len, ld_valid, ld_byte,
      output inst_sram_rdata, ld_ready, ld_busy, ld_done, cpu_hold
   );
endinterface

// File: rtl/inst_sram_loader.sv
// Instruction SRAM responder (1-cycle read, byte writes) with an embedded
// little-endian byte-stream boot loader that holds the CPU while it fills memory.
module inst_sram_loader #(
   parameter int          ADDR_WIDTH    = 12,
   parameter logic [31:0] BASE_ADDR     = 32'h1c000000,
   parameter bit          HOLD_AT_RESET = 1'b1
) (
   input logic               clk,
   input logic               resetn,
   inst_sram_loader_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH:0]     len_q, len_d;
   logic [ADDR_WIDTH:0]     words_q, words_d;
   logic [ADDR_WIDTH-1:0]   wptr_q, wptr_d;
   logic [1:0]              bytecnt_q, bytecnt_d;
   logic [2:0][7:0]         bytes_q, bytes_d;
   logic [31:0]             rdata_q, rdata_d;
   logic                    hold_q, hold_d;

   logic [31:0]             mem [DEPTH];

   logic [31:0]             offset;
   logic                    in_range;
   logic [ADDR_WIDTH-1:0]   cpu_idx;
   logic [3:0]              mem_we;
   logic [ADDR_WIDTH-1:0]   mem_waddr;
   logic [31:0]             mem_wdata;

   // Wrap-around subtraction makes addresses below BASE_ADDR land far out of range.
   assign offset   = bus.inst_sram_addr - BASE_ADDR;
   assign in_range = ((offset >> (ADDR_WIDTH + 2)) == 32'd0);
   assign cpu_idx  = offset[ADDR_WIDTH+1:2];

   always_comb begin
      // NOTE: every comb output gets a default first so no path infers a latch.
      state_d   = state_q;
      len_d     = len_q;
      words_d   = words_q;
      wptr_d    = wptr_q;
      bytecnt_d = bytecnt_q;
      bytes_d   = bytes_q;
      rdata_d   = rdata_q;
      hold_d    = hold_q;
      mem_we    = 4'b0000;
      mem_waddr = cpu_idx;
      mem_wdata = bus.inst_sram_wdata;

      unique case (state_q)
         S_IDLE: begin
            if (bus.inst_sram_en) begin
               rdata_d = in_range ? mem[cpu_idx] : 32'd0;
               if (in_range) mem_we = bus.inst_sram_we;
            end
            if (bus.ld_start) begin
               if (bus.ld_len != '0) begin
                  state_d   = S_LOAD;
                  len_d     = bus.ld_len;
                  words_d   = '0;
                  wptr_d    = '0;
                  bytecnt_d = 2'd0;
                  hold_d    = 1'b1;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_LOAD: begin
            if (bus.ld_valid) begin
               bytecnt_d = bytecnt_q + 2'd1;
               // Shift register: after three bytes, [0]=b0, [1]=b1, [2]=b2.
               bytes_d   = {bus.ld_byte, bytes_q[2], bytes_q[1]};
               if (bytecnt_q == 2'd3) begin
                  mem_we    = 4'b1111;
                  mem_waddr = wptr_q;
                  mem_wdata = {bus.ld_byte, bytes_q[2], bytes_q[1], bytes_q[0]};
                  wptr_d    = wptr_q + 1'b1;
                  words_d   = words_q + 1'b1;
                  if (words_d == len_q) state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            hold_d  = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         len_q     <= '0;
         words_q   <= '0;
         wptr_q    <= '0;
         bytecnt_q <= 2'd0;
         bytes_q   <= '0;
         rdata_q   <= 32'd0;
         hold_q    <= HOLD_AT_RESET;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         words_q   <= words_d;
         wptr_q    <= wptr_d;
         bytecnt_q <= bytecnt_d;
         bytes_q   <= bytes_d;
         rdata_q   <= rdata_d;
         hold_q    <= hold_d;
      end
   end

   // NOTE: the array has no reset so it maps onto SRAM and survives a mid-load reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (mem_we[i]) mem[mem_waddr][i*8 +: 8] <= mem_wdata[i*8 +: 8];
      end
   end

   assign bus.inst_sram_rdata = rdata_q;
   assign bus.ld_ready        = (state_q == S_LOAD);
   assign bus.ld_busy         = (state_q == S_LOAD);
   assign bus.ld_done         = (state_q == S_DONE);
   assign bus.cpu_hold        = hold_q;
endmodule
